exec_controller: RTL
====================

EXEC_CONTROLLER -- requirements
Module: exec_controller

Interface
REQ-001 The block SHALL have parameter CYCLE_W, default 16: width of the executed-instruction counter.
REQ-002 The block SHALL have parameter WDOG_LIMIT, default 1000: maximum instructions per run before a forced stop; used only under REQ-027.
REQ-003 Port clk, input, 1: single system clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port tick_in, input, 1: slow-rate pulse, one clk cycle wide, that paces execution.
REQ-006 Port run_sw, input, 1: level; 1 requests free-running execution.
REQ-007 Port step_btn, input, 1: debounced level; a rising edge requests one instruction.
REQ-008 Port halt, input, 1: level from the instruction decoder; 1 means the current instruction is HALT.
REQ-009 Port cpu_en, output, 1: registered enable for the decoder/datapath; 1 means advance one instruction this cycle.
REQ-010 Port state, output, 2: current state; IDLE=00, RUN=01, STEP=10, HALTED=11.
REQ-011 Port cycle_count, output, CYCLE_W: number of cpu_en pulses issued since reset.
REQ-012 Port timeout, output, 1: 1 means the watchdog forced HALTED.

Function
REQ-013 step_edge SHALL be step_btn high while the registered previous value of step_btn is low.
REQ-014 In IDLE, halt=1 SHALL cause HALTED next cycle; else run_sw=1 SHALL cause RUN; else step_edge SHALL cause STEP; else the state SHALL remain IDLE.
REQ-015 In RUN, halt=1 SHALL cause HALTED next cycle; else run_sw=0 SHALL cause IDLE; else the state SHALL remain RUN.
REQ-016 In RUN with halt=0 and run_sw=1, tick_in=1 in cycle N SHALL produce cpu_en=1 in cycle N+1 only.
REQ-017 In STEP, halt=1 SHALL cause HALTED with no pulse.
REQ-018 In STEP with halt=0, the first tick_in=1 (cycle N) SHALL produce cpu_en=1 in cycle N+1, and the state SHALL be IDLE in cycle N+1.
REQ-019 In STEP, the state SHALL remain STEP until a tick arrives; run_sw changes and further step edges SHALL be ignored.
REQ-020 HALTED SHALL be exited only by rst; cpu_en SHALL remain 0 in HALTED.
REQ-021 Step edges occurring in RUN or HALTED SHALL be discarded and SHALL NOT be queued.
REQ-022 cpu_en SHALL never be high in two consecutive cycles.
REQ-023 cpu_en SHALL never be issued in a cycle following one where halt=1 was sampled.
REQ-024 cycle_count SHALL increment by 1 in the cycle cpu_en is high.
REQ-025 cycle_count SHALL saturate at all-ones without wrapping.

Reset
REQ-026 On rst=1 at a clock edge, the block SHALL set state=IDLE, cpu_en=0, cycle_count=0 and timeout=0, and SHALL set the previous-step register to 1, so a button held through reset produces no step; this SHALL apply mid-RUN or mid-STEP, dropping any pending pulse.

Configuration
REQ-027 With macro EXEC_WATCHDOG_EN defined, in RUN with cycle_count >= WDOG_LIMIT the state SHALL go to HALTED next cycle with timeout=1 (held until rst) and SHALL issue no further cpu_en.
REQ-027a When the watchdog condition and halt=1 coincide, timeout SHALL still be set.
REQ-028 Without EXEC_WATCHDOG_EN, timeout SHALL be constant 0, WDOG_LIMIT SHALL be unused and RUN SHALL be unbounded.

Verification
REQ-029 Bench SHALL run: rst, run_sw=1, five tick_in pulses, halt=0 -> five single-cycle cpu_en pulses, each one cycle after its tick, state=01, cycle_count=5.
REQ-030 Bench SHALL run: IDLE, step_btn rising edge, tick after 3 cycles -> state 10 for 3 cycles, then one cpu_en, state=00, cycle_count=1; a second edge while in STEP -> no extra pulse.
REQ-031 Bench SHALL run: RUN, halt raised the same cycle as tick_in -> no cpu_en, state=11 next cycle; run_sw toggles and step edges -> remain 11 until rst.
REQ-032 Bench SHALL run: step_btn held high across rst release -> no step; release and re-press -> one STEP.
REQ-033 Bench SHALL run: CYCLE_W=4 with 20 ticks in RUN -> cycle_count stops at 15.
REQ-034 Bench SHALL run: EXEC_WATCHDOG_EN defined, WDOG_LIMIT=3, RUN with halt=0 -> exactly three pulses, then state=11 and timeout=1; without the macro -> pulses continue and timeout=0.

Source files
------------

// File: rtl/exec_controller.sv
// Execution pacing controller: gates one datapath advance per tick in RUN/STEP, latches HALT.
// Optional watchdog forcing HALTED after WDOG_LIMIT instructions is enabled by EXEC_WATCHDOG_EN.
module exec_controller #(
    parameter int CYCLE_W    = 16,
    parameter int WDOG_LIMIT = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_in,
    input  logic               run_sw,
    input  logic               step_btn,
    input  logic               halt,
    output logic               cpu_en,
    output logic [1:0]         state,
    output logic [CYCLE_W-1:0] cycle_count,
    output logic               timeout
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        STEP   = 2'b10,
        HALTED = 2'b11
    } state_t;

    state_t cur_state, next_state;
    logic   step_prev;
    logic   step_edge;
    logic   pulse;
    logic   wdog_hit;
    logic   wdog_trip;

    assign step_edge = step_btn & ~step_prev;
    assign state     = cur_state;

`ifdef EXEC_WATCHDOG_EN
    assign wdog_hit = (32'(cycle_count) >= WDOG_LIMIT);
`else
    assign wdog_hit = 1'b0;
`endif

    always_comb begin
        next_state = cur_state;
        pulse      = 1'b0;
        wdog_trip  = 1'b0;
        case (cur_state)
            IDLE: begin
                if (halt)           next_state = HALTED;
                else if (run_sw)    next_state = RUN;
                else if (step_edge) next_state = STEP;
            end
            RUN: begin
                // Watchdog is checked first so a coincident halt still records the timeout.
                if (wdog_hit) begin
                    next_state = HALTED;
                    wdog_trip  = 1'b1;
                end else if (halt) begin
                    next_state = HALTED;
                end else if (!run_sw) begin
                    next_state = IDLE;
                end else if (tick_in && !cpu_en) begin
                    pulse = 1'b1;
                end
            end
            STEP: begin
                if (halt) begin
                    next_state = HALTED;
                end else if (tick_in && !cpu_en) begin
                    pulse      = 1'b1;
                    next_state = IDLE;
                end
            end
            HALTED: next_state = HALTED;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state   <= IDLE;
            cpu_en      <= 1'b0;
            cycle_count <= '0;
            step_prev   <= 1'b1;  // a button held through reset must not count as an edge
        end else begin
            cur_state <= next_state;
            cpu_en    <= pulse;
            step_prev <= step_btn;
            if (pulse && (cycle_count != {CYCLE_W{1'b1}}))
                cycle_count <= cycle_count + 1'b1;
        end
    end

`ifdef EXEC_WATCHDOG_EN
    logic timeout_q;
    always_ff @(posedge clk) begin
        if (rst)            timeout_q <= 1'b0;
        else if (wdog_trip) timeout_q <= 1'b1;
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule
